// File: rtl/ifetch_data_stage.sv
`default_nettype none
// ============================================================================
// Module : ifetch_data_stage
// Fetch data stage: way-tag compare, L1I data read, hit/miss/near-miss report.
// Rev    : 1.0
// ============================================================================
module ifetch_data_stage #(
    parameter int NUM_WAYS   = 4,
    parameter int NUM_SETS   = 64,
    parameter int LINE_BYTES = 64,
    parameter int THREADS    = 4,
    localparam int WAY_BITS  = $clog2(NUM_WAYS),
    localparam int SET_BITS  = $clog2(NUM_SETS),
    localparam int OFS_BITS  = $clog2(LINE_BYTES),
    localparam int TAG_BITS  = 32 - SET_BITS - OFS_BITS,
    localparam int TID_BITS  = $clog2(THREADS)
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ift_instruction_requested,
    input  logic [31:0]                  ift_pc,
    input  logic [TID_BITS-1:0]          ift_thread_idx,
    input  logic [NUM_WAYS*TAG_BITS-1:0] ift_tag,
    input  logic [NUM_WAYS-1:0]          ift_valid,
    input  logic                         l2i_idata_update_en,
    input  logic [WAY_BITS-1:0]          l2i_idata_update_way,
    input  logic [SET_BITS-1:0]          l2i_idata_update_set,
    input  logic [LINE_BYTES*8-1:0]      l2i_idata_update_data,
    input  logic [NUM_WAYS-1:0]          l2i_itag_update_en_oh,
    input  logic [SET_BITS-1:0]          l2i_itag_update_set,
    input  logic                         wb_rollback_en,
    input  logic [TID_BITS-1:0]          wb_rollback_thread_idx,
    output logic                         ifd_instruction_valid,
    output logic [31:0]                  ifd_instruction,
    output logic [31:0]                  ifd_pc,
    output logic [TID_BITS-1:0]          ifd_thread_idx,
    output logic                         ifd_update_lru_en,
    output logic [WAY_BITS-1:0]          ifd_update_lru_way,
    output logic                         ifd_cache_miss,
    output logic                         ifd_near_miss,
    output logic [TID_BITS-1:0]          ifd_cache_miss_thread_idx,
    output logic                         ifd_miss_request,
    output logic [31-OFS_BITS:0]         ifd_miss_line_addr,
    output logic [31:0]                  ifd_perf_hits,
    output logic [31:0]                  ifd_perf_misses
);

    localparam int LINE_W    = LINE_BYTES * 8;
    localparam int WORDS     = LINE_BYTES / 4;
    localparam int WORD_BITS = OFS_BITS - 2;
    localparam int ADDR_BITS = WAY_BITS + SET_BITS;

    logic [TAG_BITS-1:0]  w_req_tag;
    logic [SET_BITS-1:0]  w_req_set;
    logic [WORD_BITS-1:0] w_word_idx;
    logic [NUM_WAYS-1:0]  w_way_hit;
    logic [WAY_BITS-1:0]  w_hit_way;
    logic                 w_hit;
    logic                 w_fill_now;
    logic                 w_miss;
    logic                 w_squash;
    logic [ADDR_BITS-1:0] w_rd_addr;
    logic [ADDR_BITS-1:0] w_wr_addr;
    logic [LINE_W-1:0]    w_rd_line;
    logic [31:0]          w_instr;
    logic                 w_pc_lsb_unused;

    logic [LINE_W-1:0]    r_mem [NUM_WAYS*NUM_SETS];
    logic                 r_inst_valid;
    logic [31:0]          r_instr;
    logic [31:0]          r_pc;
    logic [TID_BITS-1:0]  r_tid;
    logic                 r_miss_req;
    logic [31-OFS_BITS:0] r_line_addr;
    logic [31:0]          r_perf_hits;
    logic [31:0]          r_perf_misses;

    assign w_req_tag       = ift_pc[31 -: TAG_BITS];
    assign w_req_set       = ift_pc[OFS_BITS +: SET_BITS];
    assign w_word_idx      = ift_pc[OFS_BITS-1:2];
    assign w_pc_lsb_unused = ^ift_pc[1:0];

    generate
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            assign w_way_hit[w] = ift_valid[w] && (ift_tag[w*TAG_BITS +: TAG_BITS] == w_req_tag);
        end
    endgenerate

    // Way hits are one-hot, so OR-ing the indices encodes them.
    always_comb begin
        w_hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w_way_hit[w])
                w_hit_way = w_hit_way | WAY_BITS'(w);
        end
    end

    assign w_hit      = ift_instruction_requested && (|w_way_hit);
    assign w_fill_now = (|l2i_itag_update_en_oh) && (l2i_itag_update_set == w_req_set);
    assign w_miss     = ift_instruction_requested && !w_hit && !w_fill_now;
    assign w_squash   = wb_rollback_en && (wb_rollback_thread_idx == ift_thread_idx);

    assign w_rd_addr = {w_hit_way, w_req_set};
    assign w_wr_addr = {l2i_idata_update_way, l2i_idata_update_set};

    // A fill landing on the line being read is forwarded straight to the reader.
    assign w_rd_line = (l2i_idata_update_en && (w_wr_addr == w_rd_addr))
                     ? l2i_idata_update_data : r_mem[w_rd_addr];

    always_comb begin
        w_instr = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (w_word_idx == WORD_BITS'(i))
                w_instr = w_rd_line[(WORDS-1-i)*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (l2i_idata_update_en)
            r_mem[w_wr_addr] <= l2i_idata_update_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst_valid  <= 1'b0;
            r_instr       <= '0;
            r_pc          <= '0;
            r_tid         <= '0;
            r_miss_req    <= 1'b0;
            r_line_addr   <= '0;
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else begin
            r_inst_valid <= w_hit && !w_squash;
            r_pc         <= ift_pc;
            r_tid        <= ift_thread_idx;
            r_miss_req   <= w_miss;
            if (w_hit)
                r_instr <= w_instr;
            if (w_miss)
                r_line_addr <= ift_pc[31:OFS_BITS];
            if (w_hit && (r_perf_hits != '1))
                r_perf_hits <= r_perf_hits + 32'd1;
            if (w_miss && (r_perf_misses != '1))
                r_perf_misses <= r_perf_misses + 32'd1;
        end
    end

    assign ifd_instruction_valid     = r_inst_valid;
    assign ifd_instruction           = r_instr;
    assign ifd_pc                    = r_pc;
    assign ifd_thread_idx            = r_tid;
    assign ifd_update_lru_en         = w_hit;
    assign ifd_update_lru_way        = w_hit_way;
    assign ifd_cache_miss            = w_miss;
    assign ifd_near_miss             = ift_instruction_requested && !w_hit && w_fill_now;
    assign ifd_cache_miss_thread_idx = ift_thread_idx;
    assign ifd_miss_request          = r_miss_req;
    assign ifd_miss_line_addr        = r_line_addr;
    assign ifd_perf_hits             = r_perf_hits;
    assign ifd_perf_misses           = r_perf_misses;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_data_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_ifetch_data_stage
// Directed scoreboard bench for ifetch_data_stage.
// Rev    : 1.0
// ============================================================================
module tb_ifetch_data_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ift_instruction_requested;
    logic [31:0]  ift_pc;
    logic [1:0]   ift_thread_idx;
    logic [79:0]  ift_tag;
    logic [3:0]   ift_valid;
    logic         l2i_idata_update_en;
    logic [1:0]   l2i_idata_update_way;
    logic [5:0]   l2i_idata_update_set;
    logic [511:0] l2i_idata_update_data;
    logic [3:0]   l2i_itag_update_en_oh;
    logic [5:0]   l2i_itag_update_set;
    logic         wb_rollback_en;
    logic [1:0]   wb_rollback_thread_idx;
    logic         ifd_instruction_valid;
    logic [31:0]  ifd_instruction;
    logic [31:0]  ifd_pc;
    logic [1:0]   ifd_thread_idx;
    logic         ifd_update_lru_en;
    logic [1:0]   ifd_update_lru_way;
    logic         ifd_cache_miss;
    logic         ifd_near_miss;
    logic [1:0]   ifd_cache_miss_thread_idx;
    logic         ifd_miss_request;
    logic [25:0]  ifd_miss_line_addr;
    logic [31:0]  ifd_perf_hits;
    logic [31:0]  ifd_perf_misses;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  tid;
        logic        miss_req;
        logic [25:0] line;
    } exp_t;
    exp_t sb[$];

    ifetch_data_stage dut (
        .clk                       (clk),
        .reset                     (reset),
        .ift_instruction_requested (ift_instruction_requested),
        .ift_pc                    (ift_pc),
        .ift_thread_idx            (ift_thread_idx),
        .ift_tag                   (ift_tag),
        .ift_valid                 (ift_valid),
        .l2i_idata_update_en       (l2i_idata_update_en),
        .l2i_idata_update_way      (l2i_idata_update_way),
        .l2i_idata_update_set      (l2i_idata_update_set),
        .l2i_idata_update_data     (l2i_idata_update_data),
        .l2i_itag_update_en_oh     (l2i_itag_update_en_oh),
        .l2i_itag_update_set       (l2i_itag_update_set),
        .wb_rollback_en            (wb_rollback_en),
        .wb_rollback_thread_idx    (wb_rollback_thread_idx),
        .ifd_instruction_valid     (ifd_instruction_valid),
        .ifd_instruction           (ifd_instruction),
        .ifd_pc                    (ifd_pc),
        .ifd_thread_idx            (ifd_thread_idx),
        .ifd_update_lru_en         (ifd_update_lru_en),
        .ifd_update_lru_way        (ifd_update_lru_way),
        .ifd_cache_miss            (ifd_cache_miss),
        .ifd_near_miss             (ifd_near_miss),
        .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
        .ifd_miss_request          (ifd_miss_request),
        .ifd_miss_line_addr        (ifd_miss_line_addr),
        .ifd_perf_hits             (ifd_perf_hits),
        .ifd_perf_misses           (ifd_perf_misses)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[511-32*i -: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic [79:0] mk_tags(input logic [19:0] t0, input logic [19:0] t1,
                                            input logic [19:0] t2, input logic [19:0] t3);
        return {t3, t2, t1, t0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // More than one matching valid way is illegal stimulus.
    always @(negedge clk) begin
        int n;
        #2;
        n = 0;
        if (ift_instruction_requested === 1'b1) begin
            for (int w = 0; w < 4; w++)
                if (ift_valid[w] && ift_tag[w*20 +: 20] == ift_pc[31:12]) n++;
            assert (n <= 1) else begin
                fails++;
                $error("FAIL multi_way_hit observed=%0d expected<=1", n);
            end
        end
    end

    task automatic fill(input logic [1:0] way, input logic [5:0] set, input logic [31:0] base);
        @(negedge clk);
        l2i_idata_update_en   = 1'b1;
        l2i_idata_update_way  = way;
        l2i_idata_update_set  = set;
        l2i_idata_update_data = mk_line(base);
        @(posedge clk); #1;
        l2i_idata_update_en   = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic req, input logic [31:0] pc,
                          input logic [1:0] tid, input logic [3:0] vld, input logic [79:0] tags,
                          input logic e_hit, input logic [1:0] e_way, input logic e_miss,
                          input logic e_near, input logic e_valid, input logic [31:0] e_instr);
        exp_t e;
        @(negedge clk);
        ift_instruction_requested = req;
        ift_pc         = pc;
        ift_thread_idx = tid;
        ift_valid      = vld;
        ift_tag        = tags;
        #1;
        chk({tag, ".lru_en"}, 32'(ifd_update_lru_en), 32'(e_hit));
        if (e_hit) chk({tag, ".lru_way"}, 32'(ifd_update_lru_way), 32'(e_way));
        chk({tag, ".cache_miss"}, 32'(ifd_cache_miss), 32'(e_miss));
        chk({tag, ".near_miss"}, 32'(ifd_near_miss), 32'(e_near));
        chk({tag, ".miss_tid"}, 32'(ifd_cache_miss_thread_idx), 32'(tid));
        e.valid = e_valid; e.instr = e_instr; e.pc = pc; e.tid = tid;
        e.miss_req = e_miss; e.line = pc[31:6];
        sb.push_back(e);
        @(posedge clk); #1;
        l2i_idata_update_en       = 1'b0;
        l2i_itag_update_en_oh     = 4'b0;
        wb_rollback_en            = 1'b0;
        ift_instruction_requested = 1'b0;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, ".valid"}, 32'(ifd_instruction_valid), 32'(e.valid));
            if (e.valid) chk({tag, ".instr"}, ifd_instruction, e.instr);
            chk({tag, ".pc"}, ifd_pc, e.pc);
            chk({tag, ".tid"}, 32'(ifd_thread_idx), 32'(e.tid));
            chk({tag, ".miss_req"}, 32'(ifd_miss_request), 32'(e.miss_req));
            if (e.miss_req) chk({tag, ".line_addr"}, 32'(ifd_miss_line_addr), 32'(e.line));
        end
    endtask

    initial begin
        reset = 1'b1;
        ift_instruction_requested = 1'b0; ift_pc = '0; ift_thread_idx = '0;
        ift_tag = '0; ift_valid = '0;
        l2i_idata_update_en = 1'b0; l2i_idata_update_way = '0; l2i_idata_update_set = '0;
        l2i_idata_update_data = '0; l2i_itag_update_en_oh = '0; l2i_itag_update_set = '0;
        wb_rollback_en = 1'b0; wb_rollback_thread_idx = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.valid", 32'(ifd_instruction_valid), 32'd0);
        chk("rst.miss_req", 32'(ifd_miss_request), 32'd0);
        chk("rst.pc", ifd_pc, 32'd0);
        chk("rst.tid", 32'(ifd_thread_idx), 32'd0);
        chk("rst.instr", ifd_instruction, 32'd0);
        chk("rst.line", 32'(ifd_miss_line_addr), 32'd0);
        chk("rst.hits", ifd_perf_hits, 32'd0);
        chk("rst.misses", ifd_perf_misses, 32'd0);

        fill(2'd2, 6'd5, 32'h1000);
        fill(2'd1, 6'd5, 32'h5000);

        // Way 1 carries the same tag but is invalid, so only way 2 may hit.
        lookup("hit_w2", 1, 32'h0000_0148, 2'd1, 4'b0100, mk_tags(20'h0, 20'h0, 20'h0, 20'h0),
               1, 2'd2, 0, 0, 1, 32'h1002);
        lookup("hit_w1", 1, 32'hABCD_E14C, 2'd0, 4'b1111, mk_tags(20'h1, 20'hABCDE, 20'h2, 20'h3),
               1, 2'd1, 0, 0, 1, 32'h5003);
        lookup("miss", 1, 32'h1234_5678, 2'd2, 4'b1111, mk_tags(20'h0, 20'h0, 20'h0, 20'h0),
               0, 2'd0, 1, 0, 0, 32'h0);
        chk("miss.perf_misses", ifd_perf_misses, 32'd1);
        chk("miss.perf_hits", ifd_perf_hits, 32'd2);
        lookup("idle", 0, 32'h0000_0040, 2'd0, 4'b0000, '0, 0, 2'd0, 0, 0, 0, 32'h0);

        l2i_itag_update_en_oh = 4'b0001; l2i_itag_update_set = 6'd25;
        lookup("near", 1, 32'h1234_5678, 2'd2, 4'b1111, mk_tags(20'h0, 20'h0, 20'h0, 20'h0),
               0, 2'd0, 0, 1, 0, 32'h0);
        chk("near.perf_misses", ifd_perf_misses, 32'd1);

        l2i_itag_update_en_oh = 4'b0010; l2i_itag_update_set = 6'd26;
        lookup("fill_other_set", 1, 32'h1234_5678, 2'd2, 4'b1111, '0, 0, 2'd0, 1, 0, 0, 32'h0);
        chk("other.perf_misses", ifd_perf_misses, 32'd2);

        wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd3;
        lookup("squash_t3", 1, 32'h0000_0148, 2'd3, 4'b0100, '0, 1, 2'd2, 0, 0, 0, 32'h0);
        wb_rollback_en = 1'b1; wb_rollback_thread_idx = 2'd1;
        lookup("rollback_t1", 1, 32'h0000_0148, 2'd3, 4'b0100, '0, 1, 2'd2, 0, 0, 1, 32'h1002);

        // A fill landing on the line read in the same cycle must be seen.
        l2i_idata_update_en = 1'b1; l2i_idata_update_way = 2'd2; l2i_idata_update_set = 6'd5;
        l2i_idata_update_data = mk_line(32'h2000);
        lookup("rdw", 1, 32'h0000_0148, 2'd0, 4'b0100, '0, 1, 2'd2, 0, 0, 1, 32'h2002);
        lookup("misaligned", 1, 32'h0000_014B, 2'd0, 4'b0100, '0, 1, 2'd2, 0, 0, 1, 32'h2002);

        @(negedge clk);
        force dut.r_perf_hits = 32'hFFFF_FFFE;
        #1;
        release dut.r_perf_hits;
        for (int k = 0; k < 3; k++)
            lookup("sat_hit", 1, 32'h0000_0150, 2'd0, 4'b0100, '0, 1, 2'd2, 0, 0, 1, 32'h2004);
        chk("sat.perf_hits", ifd_perf_hits, 32'hFFFF_FFFF);
        chk("sat.perf_misses", ifd_perf_misses, 32'd2);

        // Reset lands while a miss is being looked up.
        @(negedge clk);
        ift_instruction_requested = 1'b1; ift_pc = 32'h1234_5678; ift_thread_idx = 2'd2;
        ift_valid = 4'b1111; ift_tag = '0;
        #1;
        chk("rstmiss.cache_miss", 32'(ifd_cache_miss), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        ift_instruction_requested = 1'b0; ift_pc = '0; ift_thread_idx = '0; ift_valid = '0;
        reset = 1'b0;
        sb.delete();
        #1;
        chk("rstmiss.miss_req", 32'(ifd_miss_request), 32'd0);
        chk("rstmiss.valid", 32'(ifd_instruction_valid), 32'd0);
        chk("rstmiss.line", 32'(ifd_miss_line_addr), 32'd0);
        chk("rstmiss.hits", ifd_perf_hits, 32'd0);
        chk("rstmiss.misses", ifd_perf_misses, 32'd0);
        @(posedge clk); #1;
        chk("post_rst.miss_req", 32'(ifd_miss_request), 32'd0);
        chk("post_rst.valid", 32'(ifd_instruction_valid), 32'd0);
        chk("post_rst.pc", ifd_pc, 32'd0);
        chk("post_rst.tid", 32'(ifd_thread_idx), 32'd0);
        chk("post_rst.instr", ifd_instruction, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_data_stage.md
# ifetch_data_stage

Second instruction-fetch pipeline stage, directly downstream of the fetch tag stage and upstream of instruction decode. Compares the tag-stage way tags against the fetched PC, reads the selected instruction word from the L1 instruction data SRAM, and forwards it to decode. Reports hits, misses and near-misses back to the tag stage in the same cycle. Issues L2 fill requests for misses.

## Interface
- NUM_WAYS, 4, L1I associativity.
- NUM_SETS, 64, L1I sets; SET_BITS = log2(NUM_SETS).
- LINE_BYTES, 64, cache line size; OFS_BITS = log2(LINE_BYTES); TAG_BITS = 32 - SET_BITS - OFS_BITS.
- THREADS, 4, hardware threads; TID_BITS = log2(THREADS).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- ift_instruction_requested  in  1  tag-stage slot valid.
- ift_pc  in  32  fetched PC.
- ift_thread_idx  in  TID_BITS  owning thread.
- ift_tag  in  NUM_WAYS*TAG_BITS  way tags; way w at [w*TAG_BITS +: TAG_BITS].
- ift_valid  in  NUM_WAYS  way line-valid bits.
- l2i_idata_update_en  in  1  write a line into the data SRAM.
- l2i_idata_update_way  in  log2(NUM_WAYS)  fill way.
- l2i_idata_update_set  in  SET_BITS  fill set.
- l2i_idata_update_data  in  LINE_BYTES*8  fill data; word 0 at the MSBs.
- l2i_itag_update_en_oh  in  NUM_WAYS  tag write in progress, one-hot.
- l2i_itag_update_set  in  SET_BITS  set of that tag write.
- wb_rollback_en  in  1  rollback from writeback.
- wb_rollback_thread_idx  in  TID_BITS  rolled-back thread.
- ifd_instruction_valid  out  1  instruction to decode.
- ifd_instruction  out  32  instruction word.
- ifd_pc  out  32  its PC.
- ifd_thread_idx  out  TID_BITS  its thread.
- ifd_update_lru_en  out  1  hit; touch LRU (combinational).
- ifd_update_lru_way  out  log2(NUM_WAYS)  hit way (combinational).
- ifd_cache_miss  out  1  miss (combinational).
- ifd_near_miss  out  1  retry without request (combinational).
- ifd_cache_miss_thread_idx  out  TID_BITS  = ift_thread_idx (combinational).
- ifd_miss_request  out  1  registered L2 fill request pulse.
- ifd_miss_line_addr  out  32-OFS_BITS  line address of request.
- ifd_perf_hits  out  32  saturating hit counter.
- ifd_perf_misses  out  32  saturating miss counter.

## Operation
- Request tag = ift_pc[31 -: TAG_BITS]. Request set = ift_pc[OFS_BITS +: SET_BITS]. Word = ift_pc[OFS_BITS-1:2].
- way_hit[w] = ift_valid[w] && ift_tag[w] == request tag. hit = ift_instruction_requested && |way_hit.
- More than one way_hit bit set is illegal; the bench asserts on it.
- ifd_update_lru_en = hit. ifd_update_lru_way = encoded way_hit.
- fill_now = |l2i_itag_update_en_oh && l2i_itag_update_set == request set.
- ifd_near_miss = requested && !hit && fill_now. The line is arriving, so the thread retries and no request is made.
- ifd_cache_miss = requested && !hit && !fill_now.
- Data SRAM holds NUM_WAYS*NUM_SETS lines, 1 read / 1 write port. Read address = {hit way, request set}.
- Read-during-write to the same address returns the new data.
- squash = wb_rollback_en && wb_rollback_thread_idx == ift_thread_idx.
- Misaligned PC (ift_pc[1:0] != 0) is treated as a normal lookup. The word select ignores bits 1:0.
- Perf counters increment on hit or miss, saturate at 0xFFFFFFFF, and do not count near-misses.

## Timing
- Cycle N: lookup is combinational. ifd_cache_miss, ifd_near_miss and ifd_update_lru_* are valid in N, so the tag stage can rewind the PC and sleep the thread.
- Cycle N+1:
  - ifd_instruction_valid = registered (hit && !squash).
  - ifd_instruction = selected word of the SRAM read.
  - ifd_pc and ifd_thread_idx = registered ift values. They update every cycle, valid or not.
- Cycle N+1, miss path: ifd_miss_request = registered (ifd_cache_miss). It is not suppressed by squash; the miss must still complete. ifd_miss_line_addr = ift_pc[31:OFS_BITS] registered.
- A hit in N followed by a fill of the same set/way in N reads new data only if the write lands in N (read-during-write rule).
- Back-to-back requests each cycle are supported. There is no stall input.
- Reset values: ifd_instruction_valid, ifd_miss_request, ifd_pc, ifd_thread_idx, ifd_instruction, ifd_miss_line_addr and both perf counters are 0.
- Reset mid-operation drops any in-flight result. SRAM contents are undefined after reset; validity comes from ift_valid only.

## Test plan
- Fill way 2, set 5 with words 0..15 = 0x1000+i, then request PC 0x00000148 with matching tag in way 2 only -> N: update_lru_en=1, way=2, miss=0. N+1: valid=1, instruction=0x1002.
- Request with no matching valid way and no tag write -> N: cache_miss=1, miss_thread_idx=thread. N+1: miss_request=1, line_addr=pc>>6, valid=0, perf_misses=1.
- Same miss while l2i_itag_update_en_oh=0001 and its set equals the request set -> near_miss=1, cache_miss=0, no miss_request, counters unchanged.
- Hit on thread 3 with wb_rollback_en for thread 3 in the same cycle -> update_lru_en=1, N+1 valid=0. Rollback for thread 1 instead -> valid=1.
- Preload perf_hits to 0xFFFFFFFE (force), then 3 hits -> counter holds 0xFFFFFFFF.
- Assert reset during a miss cycle -> miss_request stays 0 and all outputs read 0 until the first post-reset request.
